// File: rtl/cp0_int_ctrl.sv
// cp0_int_ctrl
// Coprocessor-0 for the five-stage MIPS pipeline. Holds SR, Cause, EPC and
// PRId, arbitrates hardware interrupts against stage-M exceptions and drives
// the handler-entry (take) and EPC signals used for flush / PC redirect.
//
// Parameters:
//   HW_INT_NUM  number of hardware interrupt lines (1..6), IM/IP bits [10+HW_INT_NUM-1:10]
//   PRID_VAL    read-only PRId contents
//   EXC_W       width of the exception code
//
// Ports:
//   clk, reset  clock, synchronous active-high reset
//   we, addr, wdata  mtc0 write from stage M
//   rdata       mfc0 read data, combinational from addr
//   pc, bd      PC and delay-slot flag of the stage-M instruction
//   exc_code    pending stage-M exception code (0 = none)
//   exl_clr     eret in stage M
//   hw_int      external interrupt lines
//   int_req     interrupt accepted this cycle
//   take        handler entry this cycle (interrupt or exception)
//   epc         current EPC
//
// Build option: define CP0_INT_EDGE_EN for synchronised, edge-captured,
// sticky IP bits that software clears through Cause writes. Without it IP
// follows hw_int with one cycle of latency and Cause is read-only.

module cp0_int_ctrl #(
    parameter int          HW_INT_NUM = 6,
    parameter logic [31:0] PRID_VAL   = 32'h0000_7A07,
    parameter int          EXC_W      = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [4:0]            addr,
    input  logic [31:0]           wdata,
    output logic [31:0]           rdata,
    input  logic [31:0]           pc,
    input  logic                  bd,
    input  logic [EXC_W-1:0]      exc_code,
    input  logic                  exl_clr,
    input  logic [HW_INT_NUM-1:0] hw_int,
    output logic                  int_req,
    output logic                  take,
    output logic [31:0]           epc
);

    localparam logic [4:0] ADDR_SR    = 5'd12;
    localparam logic [4:0] ADDR_CAUSE = 5'd13;
    localparam logic [4:0] ADDR_EPC   = 5'd14;
    localparam logic [4:0] ADDR_PRID  = 5'd15;

    logic [HW_INT_NUM-1:0] im;
    logic [HW_INT_NUM-1:0] ip;
    logic                  exl;
    logic                  ie;
    logic                  bd_r;
    logic [EXC_W-1:0]      exc_r;
    logic [31:0]           epc_r;

    logic                  exc_req;
    logic                  mtc0_ok;
    logic [31:0]           epc_new;

    // Place an interrupt vector at bits [10 +: HW_INT_NUM]; higher bits read 0.
    function automatic logic [31:0] place_irq(input logic [HW_INT_NUM-1:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < HW_INT_NUM; i++) begin
            r[10+i] = v[i];
        end
        return r;
    endfunction

    // Reset gates the requests so nothing is taken during the reset cycle.
    assign int_req = ~reset & (|(ip & im)) & ie & ~exl;
    assign exc_req = ~reset & (exc_code != '0) & ~exl;
    assign take    = int_req | exc_req;

    // The faulting / interrupted instruction must not commit its mtc0.
    assign mtc0_ok = we & ~take;
    assign epc_new = (bd ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
    assign epc     = epc_r;

    always_ff @(posedge clk) begin
        if (reset) begin
            im    <= '0;
            exl   <= 1'b0;
            ie    <= 1'b0;
            bd_r  <= 1'b0;
            exc_r <= '0;
            epc_r <= '0;
        end else if (take) begin
            // Handler entry; take implies ~exl so a concurrent eret is moot.
            exl   <= 1'b1;
            bd_r  <= bd;
            exc_r <= int_req ? '0 : exc_code;
            epc_r <= epc_new;
        end else begin
            if (exl_clr) begin
                exl <= 1'b0;
            end
            if (mtc0_ok && addr == ADDR_SR) begin
                im  <= wdata[10 +: HW_INT_NUM];
                exl <= wdata[1];
                ie  <= wdata[0];
            end
            if (mtc0_ok && addr == ADDR_EPC) begin
                epc_r <= wdata & 32'hFFFF_FFFC;
            end
        end
    end

`ifdef CP0_INT_EDGE_EN
    logic [HW_INT_NUM-1:0] sync_p0;
    logic [HW_INT_NUM-1:0] sync_p1;
    logic [HW_INT_NUM-1:0] prev_p2;
    logic [HW_INT_NUM-1:0] rise;
    logic [HW_INT_NUM-1:0] keep;

    // Two-flop synchroniser, then a previous-value flop for 0->1 detection.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_p0 <= '0;
            sync_p1 <= '0;
            prev_p2 <= '0;
        end else begin
            sync_p0 <= hw_int;
            sync_p1 <= sync_p0;
            prev_p2 <= sync_p1;
        end
    end

    assign rise = sync_p1 & ~prev_p2;
    // Cause writes clear IP bits written as 0; a same-cycle rise still sets.
    assign keep = (mtc0_ok && addr == ADDR_CAUSE) ? wdata[10 +: HW_INT_NUM] : '1;

    always_ff @(posedge clk) begin
        if (reset) begin
            ip <= '0;
        end else begin
            ip <= (ip & keep) | rise;
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            ip <= '0;
        end else begin
            ip <= hw_int;
        end
    end
`endif

    always_comb begin
        rdata = '0;
        case (addr)
            ADDR_SR:    rdata = place_irq(im) | {30'b0, exl, ie};
            ADDR_CAUSE: rdata = {bd_r, 31'b0} | place_irq(ip) | (32'(exc_r) << 2);
            ADDR_EPC:   rdata = epc_r;
            ADDR_PRID:  rdata = PRID_VAL;
            default:    rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_cp0_int_ctrl.sv
`timescale 1ns/1ps
module tb_cp0_int_ctrl;

`ifdef CP0_INT_EDGE_EN
    localparam int N = 2;
`else
    localparam int N = 6;
`endif
    localparam logic [31:0] PRID  = 32'h0000_7A07;
    localparam logic [5:0]  IMASK = 6'((1 << N) - 1);

    logic          clk;
    logic          reset;
    logic          we;
    logic [4:0]    addr;
    logic [31:0]   wdata;
    logic [31:0]   rdata;
    logic [31:0]   pc;
    logic          bd;
    logic [4:0]    exc_code;
    logic          exl_clr;
    logic [N-1:0]  hw_int;
    logic          int_req;
    logic          take;
    logic [31:0]   epc;

    int n_chk  = 0;
    int n_pass = 0;

    cp0_int_ctrl #(.HW_INT_NUM(N), .PRID_VAL(PRID), .EXC_W(5)) dut (
        .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
        .rdata(rdata), .pc(pc), .bd(bd), .exc_code(exc_code),
        .exl_clr(exl_clr), .hw_int(hw_int), .int_req(int_req),
        .take(take), .epc(epc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    // Architectural model: register contents as software sees them.
    logic          model_on = 1'b0;
    logic [5:0]    m_im, m_ip;
    logic          m_exl, m_ie, m_bd;
    logic [4:0]    m_code;
    logic [31:0]   m_epc;
    logic [N-1:0]  h0, h1, h2;   // hw_int seen at the last three edges

    function automatic logic e_int();
        return ~reset & (|(m_ip & m_im & IMASK)) & m_ie & ~m_exl;
    endfunction

    function automatic logic e_take();
        return e_int() | (~reset & (exc_code != 5'd0) & ~m_exl);
    endfunction

    function automatic logic [31:0] e_rdata();
        case (addr)
            5'd12:   return {16'b0, m_im & IMASK, 8'b0, m_exl, m_ie};
            5'd13:   return {m_bd, 15'b0, m_ip & IMASK, 3'b0, m_code, 2'b0};
            5'd14:   return m_epc;
            5'd15:   return PRID;
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin
        logic       t, i;
        logic [5:0] rise;
        if (reset) begin
            m_im = 0; m_ip = 0; m_exl = 0; m_ie = 0; m_bd = 0; m_code = 0; m_epc = 0;
            h0 = 0; h1 = 0; h2 = 0;
            model_on = 1'b1;
        end else begin
            i = e_int();
            t = e_take();
            rise = 6'(h1 & ~h2);
`ifdef CP0_INT_EDGE_EN
            if (we && addr == 5'd13 && !t) m_ip = (m_ip & wdata[15:10]) | rise;
            else m_ip = m_ip | rise;
`else
            m_ip = 6'(hw_int);
`endif
            if (t) begin
                m_exl  = 1'b1;
                m_bd   = bd;
                m_code = i ? 5'd0 : exc_code;
                m_epc  = (bd ? pc - 32'd4 : pc) & 32'hFFFF_FFFC;
            end else begin
                if (exl_clr) m_exl = 1'b0;
                if (we && addr == 5'd12) begin
                    m_im = wdata[15:10]; m_exl = wdata[1]; m_ie = wdata[0];
                end
                if (we && addr == 5'd14) m_epc = wdata & 32'hFFFF_FFFC;
            end
            h2 = h1; h1 = h0; h0 = hw_int;
        end
    end

    always @(negedge clk) begin
        if (model_on) begin
            chk("int_req", {31'b0, int_req}, {31'b0, e_int()});
            chk("take", {31'b0, take}, {31'b0, e_take()});
            chk("rdata", rdata, e_rdata());
            chk("epc", epc, m_epc);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a, input logic [31:0] exp, input string nm);
        addr = a;
        #2;
        chk(nm, rdata, exp);
        tick();
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; we = 0; addr = 0; wdata = 0; pc = 0; bd = 0;
        exc_code = 0; exl_clr = 0; hw_int = '0;
        tick(); tick();
        reset = 1'b0;

        rd(5'd15, PRID, "prid_rst");
        rd(5'd12, 32'h0, "sr_rst");
        rd(5'd13, 32'h0, "cause_rst");
        rd(5'd14, 32'h0, "epc_rst");

`ifndef CP0_INT_EDGE_EN
        // Level interrupt, then handler entry
        hw_int = 6'h01;
        wr(5'd12, 32'h0000_0401);
        pc = 32'h3008; bd = 0;
        #2;
        chk("int_req_lvl", {31'b0, int_req}, 32'd1);
        chk("take_int", {31'b0, take}, 32'd1);
        tick();
        #2;
        chk("int_req_after_take", {31'b0, int_req}, 32'd0);
        chk("epc_int", epc, 32'h3008);
        tick();
        rd(5'd12, 32'h0000_0403, "sr_exl");
        rd(5'd13, 32'h0000_0400, "cause_int");

        // eret with line still high: interrupt re-accepted next cycle
        exl_clr = 1;
        tick();
        exl_clr = 0; pc = 32'h3014;
        #2;
        chk("int_after_eret", {31'b0, int_req}, 32'd1);
        tick();
        hw_int = '0;
        tick();
        wr(5'd12, 32'h0000_0401);

        // Exception in a delay slot
        exc_code = 5'd10; bd = 1; pc = 32'h3010;
        #2;
        chk("take_exc", {31'b0, take}, 32'd1);
        chk("int_req_exc", {31'b0, int_req}, 32'd0);
        tick();
        exc_code = 0; bd = 0;
        #2;
        chk("epc_bd", epc, 32'h300C);
        tick();
        rd(5'd13, 32'h8000_0028, "cause_exc");
        exc_code = 5'd4;
        #2;
        chk("take_masked_exl", {31'b0, take}, 32'd0);
        tick();
        exc_code = 0;

        // Interrupt and exception together, mtc0 EPC suppressed
        exl_clr = 1; hw_int = 6'h01;
        tick();
        exl_clr = 0;
        exc_code = 5'd4; we = 1; addr = 5'd14; wdata = 32'hDEAD_BEEF; pc = 32'h3020; bd = 0;
        #2;
        chk("take_both", {31'b0, take}, 32'd1);
        chk("int_both", {31'b0, int_req}, 32'd1);
        tick();
        we = 0; exc_code = 0;
        #2;
        chk("epc_both", epc, 32'h3020);
        tick();
        rd(5'd13, 32'h0000_0400, "cause_both");

        // Field masks and read-only registers
        wr(5'd12, 32'hFFFF_FFFF);
        rd(5'd12, 32'h0000_FC03, "sr_mask");
        wr(5'd13, 32'h0);
        rd(5'd13, 32'h0000_0400, "cause_ro");
        wr(5'd15, 32'h0);
        rd(5'd15, PRID, "prid_ro");
        wr(5'd3, 32'hFFFF_FFFF);
        rd(5'd3, 32'h0, "unimpl");
        wr(5'd14, 32'h1234_5677);
        rd(5'd14, 32'h1234_5674, "epc_wr");

        // Reset during a take cycle
        wr(5'd12, 32'h0);
        exc_code = 5'd12; pc = 32'h3040; reset = 1;
        #2;
        chk("take_in_reset", {31'b0, take}, 32'd0);
        tick();
        reset = 0; exc_code = 0;
        #2;
        chk("epc_after_rst", epc, 32'h0);
        tick();
        rd(5'd12, 32'h0, "sr_after_rst");
`else
        // Edge capture, IE off so IP can be observed
        wr(5'd12, 32'h0000_0800);
        hw_int = 2'b10;
        tick();
        hw_int = '0;
        rd(5'd13, 32'h0, "ip_e1");
        rd(5'd13, 32'h0, "ip_e2");
        rd(5'd13, 32'h0000_0800, "ip_e3");
        rd(5'd13, 32'h0000_0800, "ip_sticky");
        wr(5'd13, 32'h0);
        rd(5'd13, 32'h0, "ip_clr");

        // Same pulse with IE on: int_req three cycles after the rise
        wr(5'd12, 32'h0000_0801);
        hw_int = 2'b10; pc = 32'h3050;
        tick();
        hw_int = '0;
        #2;
        chk("edge_lat1", {31'b0, int_req}, 32'd0);
        tick();
        #2;
        chk("edge_lat2", {31'b0, int_req}, 32'd0);
        tick();
        #2;
        chk("edge_lat3", {31'b0, int_req}, 32'd1);
        tick();
        #2;
        chk("edge_epc", epc, 32'h3050);
        tick();
`endif
        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
